mdu_sched: RTL and testbench
============================

Name: mdu_sched

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO registers; it executes the E-stage MDU ops decoded by the controller.
- Models the fixed multiply and divide latencies with a counter-driven FSM.
- Raises a D-stage stall whenever an HI/LO-class instruction would collide with an operation that is in flight or starting.
- Sits beside the ALU in stage E; its read data feeds the E→M pipeline register for mfhi/mflo.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu (≥1)
- DIV_CYC, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- E_MDU_op  in  5  E-stage op code: err=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8
- E_A  in  32  forwarded rs value
- E_B  in  32  forwarded rt value
- E_flush  in  1  E-stage instruction is a bubble; treat E_MDU_op as err
- D_mdu_use  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- busy  out  1  operation in flight
- stall  out  1  freeze F/D, bubble into E
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- MDU_RD  out  32  HI for mfhi, LO for mflo, else 0 (combinational)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, HI=LO=0, shadow result=0, busy=0.
- The stall output is combinational, so it may be 1 during reset if D_mdu_use=1 and E_MDU_op is mult–divu.
- States:
  - IDLE: busy=0.
  - MUL: busy=1.
  - DIV: busy=1.
- start = state==IDLE && !E_flush && E_MDU_op∈{1..4}.
- On start edge:
  - mult: {hi,lo}=signed E_A*E_B, 64-bit.
  - multu: {hi,lo}=unsigned E_A*E_B, 64-bit.
  - div: lo=signed quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - The result goes into shadow regs only.
  - Go to MUL with cnt=MULT_CYC-1, or to DIV with cnt=DIV_CYC-1.
- In MUL/DIV: when cnt!=0, cnt decrements each cycle. When cnt==0, HI/LO are loaded from shadow at that edge and state returns to IDLE.
- Timing: if start is at edge T, busy is high for exactly N cycles after T (N=MULT_CYC or DIV_CYC). New HI/LO are visible in the first cycle with busy=0.
- Divide by zero (E_B==0): the sequence still runs for DIV_CYC cycles. At completion HI and LO keep their prior values (shadow not loaded; commit suppressed).
- mthi/mtlo: write HI/LO from E_A at the edge when state==IDLE && !E_flush. No latency, busy stays 0.
- mfhi/mflo: MDU_RD reflects current HI/LO combinationally.
- stall = D_mdu_use && (busy || E_MDU_op∈{1..4} && !E_flush).
  - By construction, no MDU op reaches E while busy.
- Any MDU op presented while busy=1 (protocol violation) is ignored: no state change, HI/LO untouched.
- A non-MDU op, or op=err, has no effect.
- Reset asserted mid-operation: aborts immediately, HI/LO=0, state=IDLE. The pending result is lost.
- Commit edge and E-stage mthi coincident: impossible, since busy=1 blocks mthi. The commit alone takes effect.

Test Plan:
- Reset with reset=0 then release; check busy=0, HI=LO=0, MDU_RD=0. Then mult E_A=0xFFFFFFFE(-2), E_B=3 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu 0xFFFFFFFF×0xFFFFFFFF → after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- div E_A=-7 (0xFFFFFFF9), E_B=2 → busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu 7/2 → LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via mthi/mtlo; then div by 0 → busy 10 cycles, HI=0x11, LO=0x22 unchanged. mflo next → MDU_RD=0x22.
- Stall: D_mdu_use=1 in the start cycle and every busy cycle → stall=1 for 1+N cycles, 0 the cycle after. D_mdu_use=0 while busy → stall=0.
- Drop reset to 0 at busy cycle 3 of a mult → busy=0 and HI=LO=0 immediately (asynchronous). Then an op presented while busy (forced) produces no change; E_flush=1 with mthi produces no write.

Source files
------------

// File: rtl/mdu_sched.sv
// Multi-cycle multiply/divide sequencer owning HI/LO: computes the result at start,
// holds it in shadow registers for the fixed latency, then commits to HI/LO.
module mdu_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  E_MDU_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        E_flush,
  input  logic        D_mdu_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_RD
);

  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MFHI  = 5'd5;
  localparam logic [4:0] OP_MFLO  = 5'd6;
  localparam logic [4:0] OP_MTHI  = 5'd7;
  localparam logic [4:0] OP_MTLO  = 5'd8;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_commit;
  logic [31:0]   r_hi, r_lo;
  logic [31:0]   r_sh_hi, r_sh_lo;

  logic [4:0]         w_op;
  logic               w_is_md;
  logic               w_start;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic signed [31:0] w_quo_s, w_rem_s;
  logic [31:0]        w_quo_u, w_rem_u;
  logic [31:0]        w_res_hi, w_res_lo;

  // A bubble in E behaves exactly like op=err.
  assign w_op    = E_flush ? 5'd0 : E_MDU_op;
  assign w_is_md = (w_op >= OP_MULT) && (w_op <= OP_DIVU);
  assign w_start = (r_state == S_IDLE) && w_is_md;

  assign w_prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
  assign w_prod_u = {32'd0, E_A} * {32'd0, E_B};
  assign w_quo_s  = $signed(E_A) / $signed(E_B);
  assign w_rem_s  = $signed(E_A) % $signed(E_B);
  assign w_quo_u  = E_A / E_B;
  assign w_rem_u  = E_A % E_B;

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    case (w_op)
      OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
      OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
      OP_DIV:   begin w_res_hi = w_rem_s;         w_res_lo = w_quo_s;        end
      OP_DIVU:  begin w_res_hi = w_rem_u;         w_res_lo = w_quo_u;        end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_commit <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_sh_hi  <= '0;
      r_sh_lo  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_sh_hi  <= w_res_hi;
            r_sh_lo  <= w_res_lo;
            // Divide by zero still takes the full latency but never commits.
            r_commit <= !(((w_op == OP_DIV) || (w_op == OP_DIVU)) && (E_B == '0));
            r_busy   <= 1'b1;
            if ((w_op == OP_MULT) || (w_op == OP_MULTU)) begin
              r_state <= S_MUL;
              r_cnt   <= CW'(MULT_CYC - 1);
            end else begin
              r_state <= S_DIV;
              r_cnt   <= CW'(DIV_CYC - 1);
            end
          end else if (w_op == OP_MTHI) begin
            r_hi <= E_A;
          end else if (w_op == OP_MTLO) begin
            r_lo <= E_A;
          end
        end
        S_MUL, S_DIV: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            if (r_commit) begin
              r_hi <= r_sh_hi;
              r_lo <= r_sh_lo;
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign stall  = D_mdu_use && (r_busy || w_is_md);
  assign HI     = r_hi;
  assign LO     = r_lo;
  assign MDU_RD = (w_op == OP_MFHI) ? r_hi :
                  (w_op == OP_MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_mdu_sched.sv
// Randomized and directed bench for mdu_sched against an arithmetic reference of HI/LO.
module tb_mdu_sched;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  E_MDU_op;
  logic [31:0] E_A, E_B;
  logic        E_flush, D_mdu_use;
  logic        busy, stall;
  logic [31:0] HI, LO, MDU_RD;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_sched #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk(clk), .reset(reset), .E_MDU_op(E_MDU_op), .E_A(E_A), .E_B(E_B),
    .E_flush(E_flush), .D_mdu_use(D_mdu_use), .busy(busy), .stall(stall),
    .HI(HI), .LO(LO), .MDU_RD(MDU_RD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      5'd1: return 64'(sa * sb);
      5'd2: return 64'(ua * ub);
      5'd3: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  // Presents one op at a negedge with the DUT idle; viol is driven during the first busy cycle.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic fl, input logic dmu, input logic [4:0] viol);
    logic        is_md;
    logic [63:0] res;
    int          n, lat;
    is_md = !fl && (op >= 5'd1) && (op <= 5'd4);
    E_MDU_op = op; E_A = a; E_B = b; E_flush = fl; D_mdu_use = dmu;
    #1;
    chk("stall_start", {31'd0, stall}, {31'd0, dmu && is_md});
    if (!fl && op == 5'd5)      chk("rd_hi", MDU_RD, m_hi);
    else if (!fl && op == 5'd6) chk("rd_lo", MDU_RD, m_lo);
    else                        chk("rd_zero", MDU_RD, 32'd0);
    res = is_md ? model_md(op, a, b) : 64'd0;
    @(negedge clk);
    if (is_md) begin
      lat = (op <= 5'd2) ? MC : DC;
      E_MDU_op = viol; E_A = ~a; E_B = a; E_flush = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 64) begin
        #1;
        chk("stall_busy", {31'd0, stall}, {31'd0, dmu});
        E_MDU_op = 5'd0;
        n++;
        @(negedge clk);
      end
      chk("busy_len", n, lat);
      #1;
      chk("stall_after", {31'd0, stall}, 32'd0);
      if (!(op >= 5'd3 && b == 32'd0)) begin
        m_hi = res[63:32];
        m_lo = res[31:0];
      end
    end else if (!fl) begin
      if (op == 5'd7) m_hi = a;
      if (op == 5'd8) m_lo = a;
    end
    E_MDU_op = 5'd0; D_mdu_use = 1'b0; E_flush = 1'b0;
    #1;
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    @(negedge clk);
  endtask

  initial begin
    logic [4:0]  op, viol;
    logic [31:0] a, b;
    reset = 1'b0; E_MDU_op = '0; E_A = '0; E_B = '0; E_flush = 1'b0; D_mdu_use = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_rd", MDU_RD, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(5'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, 5'd0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    run_op(5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd0);
    chk("multu_hi", HI, 32'hFFFF_FFFE);
    chk("multu_lo", LO, 32'h0000_0001);
    run_op(5'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 5'd0);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    run_op(5'd4, 32'd7, 32'd2, 1'b0, 1'b0, 5'd0);
    chk("divu_hi", HI, 32'd1);
    chk("divu_lo", LO, 32'd3);
    run_op(5'd7, 32'h11, 32'd0, 1'b0, 1'b0, 5'd0);
    run_op(5'd8, 32'h22, 32'd0, 1'b0, 1'b0, 5'd0);
    run_op(5'd3, 32'd100, 32'd0, 1'b0, 1'b1, 5'd0);
    chk("dz_hi", HI, 32'h11);
    chk("dz_lo", LO, 32'h22);
    run_op(5'd6, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    run_op(5'd7, 32'hBAD0_0001, 32'd0, 1'b1, 1'b0, 5'd0);
    chk("flush_mthi", HI, 32'h11);
    run_op(5'd1, 32'd6, 32'd7, 1'b0, 1'b1, 5'd7);
    chk("viol_hi", HI, 32'd0);
    chk("viol_lo", LO, 32'd42);

    // Asynchronous reset in the middle of a multiply.
    E_MDU_op = 5'd1; E_A = 32'd9; E_B = 32'd9;
    @(negedge clk);
    E_MDU_op = 5'd0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 8));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (op == 5'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      viol = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 8)) : 5'd0;
      run_op(op, a, b, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), viol);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
